// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge: routes M-stage dmem accesses to the data RAM or the MMIO window.
// Optional CYCLE counter is built when MMIO_CYCLE_COUNTER_EN is defined.
module dmem_mmio_bridge #(
   parameter int RAM_AW     = 12,
   parameter int MMIO_BASE  = 4096,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       address_dmem,
   input  logic [31:0]       data,
   input  logic              wren,
   input  logic              rden,
   output logic [31:0]       q_dmem,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_data,
   output logic              ram_wren,
   input  logic [31:0]       ram_q,
   output logic [31:0]       tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic              rx_strobe,
   input  logic [7:0]        rx_code
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [31:0] RAM_END = 32'(1) << RAM_AW;
   localparam logic [31:0] A_TX    = 32'(MMIO_BASE);
   localparam logic [31:0] A_STAT  = 32'(MMIO_BASE + 1);
   localparam logic [31:0] A_RX    = 32'(MMIO_BASE + 2);
   localparam logic [31:0] A_CYC   = 32'(MMIO_BASE + 3);

   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic hit_ram;
   logic hit_tx;
   logic hit_stat;
   logic hit_rx;
   logic hit_cyc;

   assign hit_ram  = address_dmem < RAM_END;
   assign hit_tx   = address_dmem == A_TX;
   assign hit_stat = address_dmem == A_STAT;
   assign hit_rx   = address_dmem == A_RX;
   assign hit_cyc  = address_dmem == A_CYC;

   assign ram_addr = address_dmem[RAM_AW-1:0];
   assign ram_data = data;
   assign ram_wren = wren & hit_ram;

   logic          stat_wr;
   logic          consume;

   assign stat_wr = wren & hit_stat;
   assign consume = rden & hit_rx;

   // TX FIFO
   logic [31:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] tx_count;
   logic          tx_empty;
   logic          tx_full;
   logic          tx_ovf;
   logic          push_req;
   logic          push;
   logic          pop;

   assign tx_empty = tx_count == '0;
   assign tx_full  = tx_count == FULL_CNT;
   assign tx_valid = ~tx_empty;
   assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : '0;

   assign push_req = wren & hit_tx;
   assign pop      = tx_valid & tx_ready;
   // A full FIFO still accepts when the head leaves in the same cycle
   assign push     = push_req & (~tx_full | pop);

   always_ff @(posedge clock) begin
      if (reset && push) begin
         fifo_mem[wr_ptr] <= data;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tx_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   tx_count <= tx_count + CW'(1);
            2'b01:   tx_count <= tx_count - CW'(1);
            default: tx_count <= tx_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         tx_ovf <= 1'b0;
      end else if (push_req && !push) begin
         tx_ovf <= 1'b1;
      end else if (stat_wr && data[3]) begin
         tx_ovf <= 1'b0;
      end
   end

   // RX latch
   logic          rx_valid;
   logic          rx_lost;
   logic [7:0]    rx_reg;

   always_ff @(posedge clock) begin
      if (!reset) begin
         rx_valid <= 1'b0;
         rx_reg   <= '0;
         rx_lost  <= 1'b0;
      end else begin
         if (stat_wr && data[4]) begin
            rx_lost <= 1'b0;
         end
         if (rx_strobe) begin
            rx_reg   <= rx_code;
            rx_valid <= 1'b1;
            if (rx_valid && !consume) begin
               rx_lost <= 1'b1;
            end
         end else if (consume) begin
            rx_valid <= 1'b0;
         end
      end
   end

   logic [31:0]   cycle_val;

`ifdef MMIO_CYCLE_COUNTER_EN
   logic [31:0]   cycle_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         cycle_q <= '0;
      end else if (wren && hit_cyc) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
      end
   end

   assign cycle_val = cycle_q;
`else
   assign cycle_val = '0;
`endif

   logic [31:0]   status_word;
   logic [7:0]    count_byte;

   assign count_byte  = 8'(tx_count);
   assign status_word = {16'b0, count_byte, 3'b0,
                         rx_lost, tx_ovf, rx_valid,
                         tx_full, tx_empty};

   // Read path: registered select + registered MMIO data
   logic [31:0]   rdata_nxt;
   logic [31:0]   mmio_rdata_q;
   logic          sel_ram_q;

   always_comb begin
      rdata_nxt = '0;
      unique case (1'b1)
         hit_stat: rdata_nxt = status_word;
         hit_rx:   rdata_nxt = {24'b0, rx_reg};
         hit_cyc:  rdata_nxt = cycle_val;
         default:  rdata_nxt = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         sel_ram_q    <= 1'b1;
         mmio_rdata_q <= '0;
      end else begin
         sel_ram_q    <= hit_ram;
         mmio_rdata_q <= rdata_nxt;
      end
   end

   assign q_dmem = sel_ram_q ? ram_q : mmio_rdata_q;

endmodule
